// File: rtl/vga_msg_sequencer_if.sv
// Handshake-free signal bundle between vga_msg_sequencer and its frame/control environment.
// master = the sequencer itself, slave = whatever drives vsync/skip/pause and consumes the outputs.
interface vga_msg_sequencer_if #(
  parameter int IDX_W = 2
);
  logic             vsync_i;
  logic             skip_i;
  logic             pause_i;
  logic [IDX_W-1:0] msg_idx_o;
  logic             msg_en_o;
  logic             frame_tick_o;
  logic [1:0]       seq_state_o;

  modport master (
    input  vsync_i, skip_i, pause_i,
    output msg_idx_o, msg_en_o, frame_tick_o, seq_state_o
  );

  modport slave (
    output vsync_i, skip_i, pause_i,
    input  msg_idx_o, msg_en_o, frame_tick_o, seq_state_o
  );
endinterface

// File: rtl/vga_msg_sequencer.sv
// Frame-synchronous message scheduler: SHOW for HOLD_FRAMES, BLANK for BLANK_FRAMES, all changes at vsync.
// Optional VGA_MSG_BLINK_EN: msg_en blinks 8 frames on / 8 off while in SHOW.
module vga_msg_sequencer #(
  parameter int NUM_MSGS     = 4,
  parameter int IDX_W        = 2,
  parameter int HOLD_FRAMES  = 120,
  parameter int BLANK_FRAMES = 15,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_msg_sequencer_if.master  bus
);
  localparam logic [1:0] ST_INIT  = 2'b00;
  localparam logic [1:0] ST_SHOW  = 2'b01;
  localparam logic [1:0] ST_BLANK = 2'b10;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_MSGS - 1);

  logic             vs_d_q, skip_d_q, skip_pend_q, frame_tick_q, msg_en_q;
  logic             skip_pend_d, frame_tick_d, msg_en_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] msg_idx_q, msg_idx_d;
  logic             skip_rise;

  always_comb begin
    frame_tick_d = vs_d_q & ~bus.vsync_i;
    skip_rise    = bus.skip_i & ~skip_d_q;

    // An edge seen on the tick edge itself is kept for the following frame.
    skip_pend_d = skip_pend_q;
    if (frame_tick_q) skip_pend_d = 1'b0;
    if (skip_rise)    skip_pend_d = 1'b1;

    state_d   = state_q;
    cnt_d     = cnt_q;
    msg_idx_d = msg_idx_q;
    if (frame_tick_q) begin
      case (state_q)
        ST_INIT: begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
        ST_SHOW: begin
          if (skip_pend_q || (cnt_q == HOLD_LAST && !bus.pause_i)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
          end else if (!bus.pause_i) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          if (skip_pend_q || (cnt_q == BLANK_LAST && !bus.pause_i)) begin
            state_d   = ST_SHOW;
            cnt_d     = '0;
            msg_idx_d = (msg_idx_q == IDX_LAST) ? '0 : msg_idx_q + IDX_W'(1);
          end else if (!bus.pause_i) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef VGA_MSG_BLINK_EN
    msg_en_d = (state_d == ST_SHOW) & ~cnt_d[3];
`else
    msg_en_d = (state_d == ST_SHOW);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_q       <= 1'b1;
      skip_d_q     <= 1'b1;
      skip_pend_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      msg_idx_q    <= '0;
      msg_en_q     <= 1'b0;
    end else begin
      vs_d_q       <= bus.vsync_i;
      skip_d_q     <= bus.skip_i;
      skip_pend_q  <= skip_pend_d;
      frame_tick_q <= frame_tick_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      msg_idx_q    <= msg_idx_d;
      msg_en_q     <= msg_en_d;
    end
  end

  assign bus.msg_idx_o    = msg_idx_q;
  assign bus.msg_en_o     = msg_en_q;
  assign bus.frame_tick_o = frame_tick_q;
  assign bus.seq_state_o  = state_q;
endmodule

// File: tb/tb_vga_msg_sequencer.sv
// Randomized and directed bench for vga_msg_sequencer using short synthetic frames
// and a frame-level reference model (phase, frame count, message index).
module tb_vga_msg_sequencer;
  localparam int NUM_MSGS = 3;
  localparam int IDX_W    = 2;
  localparam int HOLD     = 4;
  localparam int BLANK    = 2;
  localparam int CNT_W    = 8;
  localparam int P_INIT = 0, P_SHOW = 1, P_BLANK = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_msg_sequencer_if #(.IDX_W(IDX_W)) bus();

  vga_msg_sequencer #(
    .NUM_MSGS(NUM_MSGS), .IDX_W(IDX_W), .HOLD_FRAMES(HOLD),
    .BLANK_FRAMES(BLANK), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which phase we are in, frames spent in it, message shown.
  int m_phase, m_cnt, m_idx;
  bit m_pend, m_lvl;

  function automatic void model_reset();
    m_phase = P_INIT; m_cnt = 0; m_idx = 0; m_pend = 0; m_lvl = 0;
  endfunction

  // One frame: the tick at its start, then the skip activity inside it.
  function automatic void model_frame(input int sk, input bit pz);
    int len;
    if (m_phase == P_INIT) begin
      m_phase = P_SHOW; m_cnt = 0;
    end else begin
      len = (m_phase == P_SHOW) ? HOLD : BLANK;
      if (m_pend || (!pz && m_cnt + 1 >= len)) begin
        if (m_phase == P_BLANK) m_idx = (m_idx + 1) % NUM_MSGS;
        m_phase = (m_phase == P_SHOW) ? P_BLANK : P_SHOW;
        m_cnt   = 0;
      end else if (!pz) begin
        m_cnt = m_cnt + 1;
      end
    end
    m_pend = (sk != 0) && !m_lvl;
    m_lvl  = (sk == 2);
  endfunction

  function automatic logic [IDX_W+2:0] model_outs();
    logic en;
`ifdef VGA_MSG_BLINK_EN
    en = (m_phase == P_SHOW) && ((m_cnt / 8) % 2 == 0);
`else
    en = (m_phase == P_SHOW);
`endif
    return {2'(m_phase), IDX_W'(m_idx), en};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.vsync_i = 1'b1; bus.skip_i = 1'b0; bus.pause_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // sk: 0 = skip low, 1 = one pulse mid-frame, 2 = skip driven high and left high.
  task automatic run_frame(input int sk, input bit pz, output int ticks);
    ticks = 0;
    @(negedge clk);
    bus.pause_i = pz;
    bus.vsync_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.frame_tick_o === 1'b1) ticks++;
      if (c == 1) bus.vsync_i = 1'b1;
      if (c == 4 && sk != 0) bus.skip_i = 1'b1;
      if (c == 6 && sk != 2) bus.skip_i = 1'b0;
    end
    model_frame(sk, pz);
  endtask

  task automatic test_reset();
    int ticks;
    rst_n = 1'b0; bus.vsync_i = 1'b1; bus.skip_i = 1'b0; bus.pause_i = 1'b0;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if ({bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o, bus.frame_tick_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b expected %b",
               {bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o, bus.frame_tick_o}, 6'b0);
    end
    rst_n = 1'b1;
    model_reset();
    ticks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.frame_tick_o === 1'b1) ticks++;
    end
    n_tests++;
    if (ticks != 0 || bus.seq_state_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: ticks=%0d state=%b expected ticks=0 state=00", ticks, bus.seq_state_o);
    end
  endtask

  task automatic test_basic();
    int t;
    do_reset();
    for (int f = 1; f <= 7; f++) begin
      run_frame(0, 1'b0, t);
      n_tests++;
      if (t != 1) begin n_fail++; $display("FAIL basic_tick f%0d: got %0d ticks expected 1", f, t); end
      n_tests++;
      if ({bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o} !== model_outs()) begin
        n_fail++;
        $display("FAIL basic_outs f%0d: got %b expected %b", f,
                 {bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o}, model_outs());
      end
      if (f == 1 || f == 5 || f == 7) begin
        n_tests++;
        if ((f == 1 && {bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o} !== 5'b01_00_1) ||
            (f == 5 && {bus.seq_state_o, bus.msg_en_o} !== 3'b10_0) ||
            (f == 7 && {bus.seq_state_o, bus.msg_idx_o} !== 4'b01_01)) begin
          n_fail++;
          $display("FAIL basic_fixed f%0d: got state=%b idx=%0d en=%b", f,
                   bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int t;
    int seen[$];
    int want[4];
    logic [1:0] prev;
    want[0] = 0; want[1] = 1; want[2] = 2; want[3] = 0;
    do_reset();
    prev = 2'b00;
    for (int f = 1; f <= 1 + 3 * (HOLD + BLANK); f++) begin
      run_frame(0, 1'b0, t);
      n_tests++;
      if (t != 1) begin n_fail++; $display("FAIL wrap_tick f%0d: got %0d ticks expected 1", f, t); end
      n_tests++;
      if ({bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o} !== model_outs()) begin
        n_fail++;
        $display("FAIL wrap_outs f%0d: got %b expected %b", f,
                 {bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o}, model_outs());
      end
      if (bus.seq_state_o == 2'b01 && prev != 2'b01) seen.push_back(int'(bus.msg_idx_o));
      prev = bus.seq_state_o;
    end
    n_tests++;
    if (seen.size() != 4 || seen[0] != want[0] || seen[1] != want[1] ||
        seen[2] != want[2] || seen[3] != want[3]) begin
      n_fail++;
      $display("FAIL wrap_seq: got %p expected 0 1 2 0", seen);
    end
  endtask

  task automatic test_skip();
    int t;
    do_reset();
    run_frame(0, 1'b0, t);
    run_frame(1, 1'b0, t);
    run_frame(0, 1'b0, t);
    n_tests++;
    if (bus.seq_state_o !== 2'b10 || {bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o} !== model_outs()) begin
      n_fail++;
      $display("FAIL skip_pulse: got state=%b idx=%0d expected state=10 idx=0", bus.seq_state_o, bus.msg_idx_o);
    end
    do_reset();
    run_frame(0, 1'b0, t);
    for (int f = 0; f < 3; f++) run_frame(2, 1'b0, t);
    n_tests++;
    if ({bus.seq_state_o, bus.msg_idx_o} !== 4'b10_00) begin
      n_fail++;
      $display("FAIL skip_hold_blank: got state=%b idx=%0d expected state=10 idx=0", bus.seq_state_o, bus.msg_idx_o);
    end
    run_frame(0, 1'b0, t);
    run_frame(0, 1'b0, t);
    n_tests++;
    if ({bus.seq_state_o, bus.msg_idx_o} !== 4'b01_01 ||
        {bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o} !== model_outs()) begin
      n_fail++;
      $display("FAIL skip_hold_once: got state=%b idx=%0d expected state=01 idx=1", bus.seq_state_o, bus.msg_idx_o);
    end
  endtask

  task automatic test_coincide();
    int t;
    logic [3:0] want [3];
    want[0] = 4'b10_00; want[1] = 4'b10_00; want[2] = 4'b01_01;
    do_reset();
    for (int f = 0; f < 3; f++) run_frame(0, 1'b0, t);
    run_frame(1, 1'b0, t);
    for (int f = 0; f < 3; f++) begin
      run_frame(0, 1'b0, t);
      n_tests++;
      if ({bus.seq_state_o, bus.msg_idx_o} !== want[f]) begin
        n_fail++;
        $display("FAIL coincide step%0d: got state/idx %b expected %b", f, {bus.seq_state_o, bus.msg_idx_o}, want[f]);
      end
    end
  endtask

  task automatic test_pause();
    int t;
    do_reset();
    for (int f = 0; f < 3; f++) run_frame(0, 1'b0, t);
    for (int f = 0; f < 10; f++) begin
      run_frame((f == 9) ? 1 : 0, 1'b1, t);
      n_tests++;
      if (bus.seq_state_o !== 2'b01 || bus.msg_en_o !== 1'b1) begin
        n_fail++;
        $display("FAIL pause_hold p%0d: got state=%b en=%b expected state=01 en=1", f, bus.seq_state_o, bus.msg_en_o);
      end
    end
    run_frame(0, 1'b1, t);
    n_tests++;
    if (bus.seq_state_o !== 2'b10) begin
      n_fail++;
      $display("FAIL pause_skip: got state=%b expected 10", bus.seq_state_o);
    end
    run_frame(0, 1'b1, t);
    run_frame(0, 1'b0, t);
    run_frame(0, 1'b0, t);
    n_tests++;
    if ({bus.seq_state_o, bus.msg_idx_o} !== 4'b01_01) begin
      n_fail++;
      $display("FAIL pause_blank_resume: got state/idx %b expected 0101", {bus.seq_state_o, bus.msg_idx_o});
    end
    // Counter resumes from 2 after release: one more SHOW frame, then BLANK.
    do_reset();
    for (int f = 0; f < 3; f++) run_frame(0, 1'b0, t);
    for (int f = 0; f < 3; f++) run_frame(0, 1'b1, t);
    run_frame(0, 1'b0, t);
    n_tests++;
    if (bus.seq_state_o !== 2'b01) begin
      n_fail++;
      $display("FAIL pause_resume_show: got state=%b expected 01", bus.seq_state_o);
    end
    run_frame(0, 1'b0, t);
    n_tests++;
    if (bus.seq_state_o !== 2'b10) begin
      n_fail++;
      $display("FAIL pause_resume_blank: got state=%b expected 10", bus.seq_state_o);
    end
  endtask

  task automatic test_random();
    int t, r, sk;
    bit pz;
    do_reset();
    for (int f = 0; f < 80; f++) begin
      r  = $urandom_range(0, 9);
      sk = (r < 2) ? 1 : (r < 3) ? 2 : 0;
      pz = ($urandom_range(0, 3) == 0);
      run_frame(sk, pz, t);
      n_tests++;
      if (t != 1 || {bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o} !== model_outs()) begin
        n_fail++;
        $display("FAIL random f%0d sk=%0d pz=%0d: got ticks=%0d outs=%b expected ticks=1 outs=%b",
                 f, sk, pz, t, {bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o}, model_outs());
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, ticks;
    do_reset();
    for (int f = 0; f < 5; f++) run_frame(0, 1'b0, t);
    run_frame(1, 1'b0, t);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o, bus.frame_tick_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b expected %b",
               {bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o, bus.frame_tick_o}, 6'b0);
    end
    @(negedge clk);
    bus.skip_i = 1'b0;
    rst_n = 1'b1;
    model_reset();
    ticks = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.frame_tick_o === 1'b1) ticks++;
    end
    n_tests++;
    if (ticks != 0) begin
      n_fail++;
      $display("FAIL reset_mid_notick: got %0d ticks expected 0", ticks);
    end
    run_frame(0, 1'b0, t);
    run_frame(0, 1'b0, t);
    n_tests++;
    if ({bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o} !== 5'b01_00_1 ||
        {bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o} !== model_outs()) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got %b expected %b",
               {bus.seq_state_o, bus.msg_idx_o, bus.msg_en_o}, 5'b01_00_1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_skip();
    test_coincide();
    test_pause();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
